alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Registered issue stage driving the execute-stage ALU. It accepts decoded instruction fields and register operands from decode, and encodes ALUOp/Funct3/Funct7 into the ALU's 4-bit Operation code. It selects SrcA/SrcB and holds them in a valid/ready pipeline register in front of the ALU, with stall and flush. The ALU is purely combinational and consumes the registered outputs directly.

## Interface
- DATA_WIDTH, 32, operand width
- OPCODE_LENGTH, 4, width of Operation code
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- InValid  in  1  decode presents an operation
- InReady  out  1  stage can accept this cycle
- ALUOp  in  2  00 load/store, 01 branch, 10 R/I arithmetic, 11 LUI
- Funct3  in  3  instruction funct3
- Funct7  in  7  instruction funct7
- IsImm  in  1  SrcB comes from Imm, not Rs2Data
- Rs1Data  in  DATA_WIDTH  register operand 1
- Rs2Data  in  DATA_WIDTH  register operand 2
- Imm  in  DATA_WIDTH  sign-extended immediate
- Flush  in  1  kill held and incoming operation
- OutValid  out  1  registered outputs valid
- OutReady  in  1  execute consumes this cycle
- SrcA, SrcB  out  DATA_WIDTH  registered ALU operands
- Operation  out  OPCODE_LENGTH  registered ALU code
- Illegal  out  1  registered: encoding unsupported by ALU

## Operation
- Operation codes: AND 0000, OR 0001, ADD 0010, SUB 0011, SLL 0100, SRL 0101, SRA 0111, EQ 1000, XOR 1001, SLT 1100.
- ALUOp 00: ADD, SrcA=Rs1Data, SrcB=Imm.
- ALUOp 01: Funct3 000/001 -> EQ; 100/101 -> SLT; other -> Illegal. SrcB=Rs2Data.
- ALUOp 10: Funct3 000 -> SUB if !IsImm && Funct7=0100000, else ADD; 001 SLL; 010 SLT; 100 XOR; 101 -> SRA if Funct7[5], else SRL; 110 OR; 111 AND; 011 (SLTU) -> Illegal.
- ALUOp 10, R-type (!IsImm): Funct7 other than 0000000, or 0100000 with Funct3 other than 000/101 -> Illegal.
- ALUOp 10, shift-immediate: Funct7 other than 0000000/0100000 -> Illegal.
- ALUOp 11: ADD, SrcA=0, SrcB=Imm.
- SrcB = IsImm ? Imm : Rs2Data, except ALUOp 00/11 always use Imm. Shift operands pass unmodified; the ALU uses SrcB[4:0].
- Illegal ops still issue, with Operation=0000 and Illegal=1. Execute decides how to trap.

## Timing
- InReady = !Flush && (!OutValid || OutReady), combinational.
- Accept when InValid && InReady; outputs load at that edge. Latency 1 cycle.
- Hold: OutValid && !OutReady keeps SrcA/SrcB/Operation/Illegal stable.
- Drain: OutValid && OutReady && !(InValid && InReady) -> OutValid=0 next cycle; data regs keep their value.
- Back-to-back: consume and accept in the same cycle gives full throughput, one op per cycle.
- Flush: OutValid=0 next cycle. Incoming op is not captured (InReady=0). Flush beats OutReady.
- Reset: OutValid=0, SrcA=0, SrcB=0, Operation=0000, Illegal=0, counters 0. Takes effect mid-hold; the held op is lost.

## Configuration
- ALU_ISSUE_PERF_EN defined: adds outputs IssueCount and IllegalCount, each 32 bits.
  - IssueCount increments on each OutValid && OutReady.
  - IllegalCount increments on each such handshake with Illegal=1.
  - Both wrap 0xFFFFFFFF -> 0 and clear on reset. Flushed ops are not counted.
- ALU_ISSUE_PERF_EN undefined: ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package alu_pkg:
  - enum alu_op_e holding the 10 Operation codes above.
  - enum alu_ctrl_e for ALUOp values.
  - Funct7 constants F7_BASE=0000000 and F7_ALT=0100000.
  - The ALU should import the same enum.
- Sub-module alu_op_decode, combinational: inputs ALUOp/Funct3/Funct7/IsImm; outputs Operation, Illegal, SrcBSel, ZeroA.
- The top holds the handshake and pipeline register and, under the macro, the counters.

## Test plan
- R-type SUB: ALUOp=10, Funct3=000, Funct7=0100000, IsImm=0, Rs1=7, Rs2=3, OutReady=1 -> next cycle OutValid=1, Operation=0011, SrcA=7, SrcB=3.
- SRAI: ALUOp=10, Funct3=101, Funct7=0100000, IsImm=1, Imm=0x405 -> Operation=0111, SrcB=0x405, Illegal=0.
- Stall: two ops back-to-back with OutReady=0 for 3 cycles. First op is held stable; InReady=0 while held. Second op issues the cycle after OutReady=1 and no op is lost.
- Flush with OutValid=1 and InValid=1 -> InReady=0, OutValid=0 next cycle, incoming op discarded.
- SLTU R-type (Funct3=011) -> Operation=0000, Illegal=1. With the macro: IllegalCount=1 and IssueCount=1 after the handshake.
- LUI: ALUOp=11, Imm=0x12345000, Rs1Data=0xFFFF -> SrcA=0, SrcB=0x12345000, Operation=0010. Reset asserted mid-hold -> all outputs 0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage and the execute-stage ALU.
// The ALU imports alu_op_e from here so both sides agree on Operation codes.
package alu_pkg;

    // ALU Operation codes; the ALU decodes exactly these values.
    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_SLL = 4'b0100,
        OP_SRL = 4'b0101,
        OP_SRA = 4'b0111,
        OP_EQ  = 4'b1000,
        OP_XOR = 4'b1001,
        OP_SLT = 4'b1100
    } alu_op_e;

    // ALUOp classes produced by the main decoder.
    typedef enum logic [1:0] {
        CTRL_MEM    = 2'b00,
        CTRL_BRANCH = 2'b01,
        CTRL_ARITH  = 2'b10,
        CTRL_LUI    = 2'b11
    } alu_ctrl_e;

    // Second ALU operand source.
    typedef enum logic {
        SRCB_RS2 = 1'b0,
        SRCB_IMM = 1'b1
    } srcb_sel_e;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Shift funct3 values (SLL/SLLI, SRL/SRA and their immediate forms).
    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU control decode: ALUOp/Funct3/Funct7/IsImm to the ALU
// Operation code, an Illegal flag and the operand-select controls.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] Funct3,
    input  logic [6:0] Funct7,
    input  logic       IsImm,
    output logic [3:0] Operation,
    output logic       Illegal,
    output logic       SrcBSel,
    output logic       ZeroA
);

    alu_op_e   w_op;
    logic      w_illegal;
    srcb_sel_e w_srcb_sel;

    // Decode the operation and legality; illegal encodings collapse to AND.
    always_comb begin
        w_op       = OP_ADD;
        w_illegal  = 1'b0;
        w_srcb_sel = SRCB_IMM;
        ZeroA      = 1'b0;

        case (alu_ctrl_e'(ALUOp))
            CTRL_MEM: begin
                w_op = OP_ADD;
            end
            CTRL_BRANCH: begin
                w_srcb_sel = SRCB_RS2;
                case (Funct3)
                    3'b000, 3'b001: w_op = OP_EQ;
                    3'b100, 3'b101: w_op = OP_SLT;
                    default:        w_illegal = 1'b1;
                endcase
            end
            CTRL_ARITH: begin
                w_srcb_sel = IsImm ? SRCB_IMM : SRCB_RS2;
                case (Funct3)
                    3'b000:  w_op = (!IsImm && Funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                    3'b001:  w_op = OP_SLL;
                    3'b010:  w_op = OP_SLT;
                    3'b011:  w_illegal = 1'b1;
                    3'b100:  w_op = OP_XOR;
                    3'b101:  w_op = Funct7[5] ? OP_SRA : OP_SRL;
                    3'b110:  w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
                if (!IsImm) begin
                    // R-type: only the base Funct7, or the alternate one on SUB/SRA.
                    if (Funct7 != F7_BASE &&
                        !(Funct7 == F7_ALT && (Funct3 == 3'b000 || Funct3 == 3'b101)))
                        w_illegal = 1'b1;
                end else if (is_shift(Funct3)) begin
                    // Shift-immediate: upper immediate bits act as Funct7.
                    if (Funct7 != F7_BASE && Funct7 != F7_ALT)
                        w_illegal = 1'b1;
                end
            end
            CTRL_LUI: begin
                w_op  = OP_ADD;
                ZeroA = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign Illegal   = w_illegal;
    assign Operation = w_illegal ? OP_AND : w_op;
    assign SrcBSel   = w_srcb_sel;

endmodule

// File: rtl/alu_issue_stage.sv
// Registered issue stage in front of the combinational execute-stage ALU.
// Valid/ready pipeline register with stall and flush.
// Optional performance counters are enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [1:0]               ALUOp,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic                     IsImm,
    input  logic [DATA_WIDTH-1:0]    Rs1Data,
    input  logic [DATA_WIDTH-1:0]    Rs2Data,
    input  logic [DATA_WIDTH-1:0]    Imm,
    input  logic                     Flush,
    output logic                     OutValid,
    input  logic                     OutReady,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     Illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]              IssueCount,
    output logic [31:0]              IllegalCount
`endif
);

    logic                     r_valid;
    logic [DATA_WIDTH-1:0]    r_srca;
    logic [DATA_WIDTH-1:0]    r_srcb;
    logic [OPCODE_LENGTH-1:0] r_operation;
    logic                     r_illegal;

    logic [3:0]               w_dec_op;
    logic                     w_dec_illegal;
    logic                     w_dec_srcb_sel;
    logic                     w_dec_zero_a;
    logic [DATA_WIDTH-1:0]    w_srca;
    logic [DATA_WIDTH-1:0]    w_srcb;
    logic                     w_in_ready;
    logic                     w_accept;

    alu_op_decode u_decode (
        .ALUOp     (ALUOp),
        .Funct3    (Funct3),
        .Funct7    (Funct7),
        .IsImm     (IsImm),
        .Operation (w_dec_op),
        .Illegal   (w_dec_illegal),
        .SrcBSel   (w_dec_srcb_sel),
        .ZeroA     (w_dec_zero_a)
    );

    // Handshake and operand selection.
    always_comb begin
        w_in_ready = !Flush && (!r_valid || OutReady);
        w_accept   = InValid && w_in_ready;
        w_srca     = w_dec_zero_a ? '0 : Rs1Data;
        w_srcb     = (w_dec_srcb_sel == SRCB_IMM) ? Imm : Rs2Data;
    end

    // Pipeline register: flush kills, accept loads, drain clears valid only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_srca      <= '0;
            r_srcb      <= '0;
            r_operation <= '0;
            r_illegal   <= 1'b0;
        end else if (Flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_srca      <= w_srca;
            r_srcb      <= w_srcb;
            r_operation <= OPCODE_LENGTH'(w_dec_op);
            r_illegal   <= w_dec_illegal;
        end else if (OutReady) begin
            r_valid <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic        r_issue_count;
    logic [31:0] r_issue_cnt;
    logic [31:0] r_illegal_cnt;
    logic        w_consume;

    // A flushed op is not consumed even if execute signals ready.
    assign w_consume = r_valid && OutReady && !Flush;

    // Free-running wrap-around handshake counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_cnt   <= '0;
            r_illegal_cnt <= '0;
            r_issue_count <= 1'b0;
        end else begin
            r_issue_count <= w_consume;
            if (w_consume) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
                if (r_illegal)
                    r_illegal_cnt <= r_illegal_cnt + 32'd1;
            end
        end
    end

    assign IssueCount   = r_issue_cnt;
    assign IllegalCount = r_illegal_cnt;
`endif

    assign InReady   = w_in_ready;
    assign OutValid  = r_valid;
    assign SrcA      = r_srca;
    assign SrcB      = r_srcb;
    assign Operation = r_operation;
    assign Illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage. Counter checks are compiled in when
// ALU_ISSUE_PERF_EN is defined.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        InValid;
    logic        InReady;
    logic [1:0]  ALUOp;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic        IsImm;
    logic [31:0] Rs1Data;
    logic [31:0] Rs2Data;
    logic [31:0] Imm;
    logic        Flush;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        Illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] IssueCount;
    logic [31:0] IllegalCount;
`endif

    alu_issue_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .ALUOp     (ALUOp),
        .Funct3    (Funct3),
        .Funct7    (Funct7),
        .IsImm     (IsImm),
        .Rs1Data   (Rs1Data),
        .Rs2Data   (Rs2Data),
        .Imm       (Imm),
        .Flush     (Flush),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .Operation (Operation),
        .Illegal   (Illegal)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .IssueCount   (IssueCount),
        .IllegalCount (IllegalCount)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_issue   = 0;
    int   m_illegal = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every consumed output against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && OutValid && OutReady && !Flush) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL monitor: unexpected output op=%h a=%h b=%h", Operation, SrcA, SrcB);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_srca", SrcA, e.a);
                check("out_srcb", SrcB, e.b);
                check("out_op", {28'd0, Operation}, {28'd0, e.op});
                check("out_illegal", {31'd0, Illegal}, {31'd0, e.ill});
                m_issue++;
                if (e.ill) m_illegal++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic issue(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic imm_sel, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] immv, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [3:0] eop, input logic eill);
        bit accepted = 0;
        exp_t e;
        ALUOp = aop; Funct3 = f3; Funct7 = f7; IsImm = imm_sel;
        Rs1Data = rs1; Rs2Data = rs2; Imm = immv;
        InValid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (InReady) begin
                e.a = ea; e.b = eb; e.op = eop; e.ill = eill;
                q.push_back(e);
                accepted = 1;
            end
            @(posedge clk); #1;
        end
        InValid = 1'b0;
        if (!accepted) check("issue_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
        ALUOp = '0; Funct3 = '0; Funct7 = '0; IsImm = 1'b0;
        Rs1Data = '0; Rs2Data = '0; Imm = '0;
        cycles(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst_outvalid", {31'd0, OutValid}, 32'd0);
        check("rst_srca", SrcA, 32'd0);
        check("rst_srcb", SrcB, 32'd0);
        check("rst_op", {28'd0, Operation}, 32'd0);
        check("rst_illegal", {31'd0, Illegal}, 32'd0);
        check("rst_inready", {31'd0, InReady}, 32'd1);
`ifdef ALU_ISSUE_PERF_EN
        check("rst_issuecnt", IssueCount, 32'd0);
        check("rst_illegalcnt", IllegalCount, 32'd0);
`endif
        @(posedge clk); #1;

        // SLTU R-type: illegal, issued as AND.
        issue(2'b10, 3'b011, 7'b0000000, 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 32'd9, 4'b0000, 1'b1);
        cycles(1);
`ifdef ALU_ISSUE_PERF_EN
        check("sltu_issuecnt", IssueCount, 32'd1);
        check("sltu_illegalcnt", IllegalCount, 32'd1);
`endif

        // Directed decode vectors, full throughput.
        issue(2'b10, 3'b000, 7'b0100000, 1'b0, 32'd7, 32'd3, 32'hFFF, 32'd7, 32'd3, 4'b0011, 1'b0);      // SUB
        issue(2'b10, 3'b101, 7'b0100000, 1'b1, 32'h80000000, 32'd1, 32'h405, 32'h80000000, 32'h405, 4'b0111, 1'b0); // SRAI
        issue(2'b00, 3'b010, 7'b0000000, 1'b0, 32'h100, 32'hDEAD, 32'd8, 32'h100, 32'd8, 4'b0010, 1'b0); // load
        issue(2'b01, 3'b000, 7'b0000000, 1'b0, 32'd4, 32'd4, 32'h20, 32'd4, 32'd4, 4'b1000, 1'b0);       // BEQ
        issue(2'b01, 3'b100, 7'b0000000, 1'b0, 32'd1, 32'd2, 32'h20, 32'd1, 32'd2, 4'b1100, 1'b0);       // BLT
        issue(2'b01, 3'b010, 7'b0000000, 1'b0, 32'd1, 32'd2, 32'h20, 32'd1, 32'd2, 4'b0000, 1'b1);       // bad branch
        issue(2'b10, 3'b000, 7'b0000000, 1'b0, 32'd10, 32'd20, 32'd0, 32'd10, 32'd20, 4'b0010, 1'b0);    // ADD
        issue(2'b10, 3'b100, 7'b0000000, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'hF0, 32'h0F, 4'b1001, 1'b0);    // XOR
        issue(2'b10, 3'b110, 7'b0100000, 1'b0, 32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 4'b0000, 1'b1);        // OR with alt f7
        issue(2'b10, 3'b000, 7'b0100000, 1'b1, 32'd6, 32'd9, 32'hFFFFFC00, 32'd6, 32'hFFFFFC00, 4'b0010, 1'b0); // ADDI
        issue(2'b10, 3'b101, 7'b0000000, 1'b1, 32'd6, 32'd9, 32'd3, 32'd6, 32'd3, 4'b0101, 1'b0);        // SRLI
        issue(2'b10, 3'b001, 7'b0000001, 1'b1, 32'd6, 32'd9, 32'h23, 32'd6, 32'h23, 4'b0000, 1'b1);      // bad SLLI
        issue(2'b10, 3'b010, 7'b0000000, 1'b0, 32'd3, 32'd4, 32'd0, 32'd3, 32'd4, 4'b1100, 1'b0);        // SLT
        issue(2'b10, 3'b110, 7'b0000000, 1'b1, 32'd3, 32'd4, 32'h55, 32'd3, 32'h55, 4'b0001, 1'b0);      // ORI
        issue(2'b10, 3'b111, 7'b0000000, 1'b0, 32'hFF, 32'h0F, 32'd0, 32'hFF, 32'h0F, 4'b0000, 1'b0);    // AND
        issue(2'b10, 3'b001, 7'b0000000, 1'b0, 32'd1, 32'd4, 32'd0, 32'd1, 32'd4, 4'b0100, 1'b0);        // SLL
        cycles(2);

        // Stall: first op held for 3 cycles, second issues once ready returns.
        OutReady = 1'b0;
        issue(2'b10, 3'b100, 7'b0000000, 1'b0, 32'hAA, 32'h55, 32'd0, 32'hAA, 32'h55, 4'b1001, 1'b0);
        fork
            issue(2'b10, 3'b000, 7'b0000000, 1'b1, 32'd100, 32'd0, 32'd23, 32'd100, 32'd23, 4'b0010, 1'b0);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("hold_valid", {31'd0, OutValid}, 32'd1);
                    check("hold_inready", {31'd0, InReady}, 32'd0);
                    check("hold_srca", SrcA, 32'hAA);
                    check("hold_srcb", SrcB, 32'h55);
                    check("hold_op", {28'd0, Operation}, 32'h9);
                end
                @(posedge clk); #1;
                OutReady = 1'b1;
            end
        join
        cycles(2);

        // Flush with a held op and an incoming op: both are discarded.
        OutReady = 1'b0;
        issue(2'b10, 3'b110, 7'b0000000, 1'b1, 32'd1, 32'd0, 32'h77, 32'd1, 32'h77, 4'b0001, 1'b0);
        ALUOp = 2'b10; Funct3 = 3'b111; Funct7 = 7'b0000000; IsImm = 1'b0;
        Rs1Data = 32'h1234; Rs2Data = 32'h5678;
        InValid = 1'b1; Flush = 1'b1; OutReady = 1'b1;
        @(negedge clk);
        check("flush_inready", {31'd0, InReady}, 32'd0);
        check("flush_outvalid_before", {31'd0, OutValid}, 32'd1);
        @(posedge clk); #1;
        Flush = 1'b0; InValid = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        check("flush_outvalid_after", {31'd0, OutValid}, 32'd0);
        check("flush_srca_kept", SrcA, 32'd1);
        @(posedge clk); #1;

        // LUI held, then reset mid-hold.
        OutReady = 1'b0;
        issue(2'b11, 3'b000, 7'b0000000, 1'b0, 32'hFFFF, 32'h9, 32'h12345000, 32'd0, 32'h12345000, 4'b0010, 1'b0);
        @(negedge clk);
        check("lui_valid", {31'd0, OutValid}, 32'd1);
        check("lui_srca", SrcA, 32'd0);
        check("lui_srcb", SrcB, 32'h12345000);
        check("lui_op", {28'd0, Operation}, 32'h2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q.delete();
        m_issue = 0;
        m_illegal = 0;
        @(negedge clk);
        check("midrst_valid", {31'd0, OutValid}, 32'd0);
        check("midrst_srcb", SrcB, 32'd0);
        check("midrst_op", {28'd0, Operation}, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
        check("midrst_issuecnt", IssueCount, 32'd0);
`endif
        @(posedge clk); #1;

        // After reset: one more op to confirm normal operation resumes.
        OutReady = 1'b1;
        issue(2'b10, 3'b000, 7'b0100000, 1'b0, 32'd50, 32'd8, 32'd0, 32'd50, 32'd8, 4'b0011, 1'b0);
        cycles(3);
        check("queue_drained", q.size(), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
        check("end_issuecnt", IssueCount, m_issue);
        check("end_illegalcnt", IllegalCount, m_illegal);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
